// File: rtl/atom_mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : atom_mem_arbiter_pkg
// Brief    : Shared state encoding and master IDs for the imem/dmem arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package atom_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef logic master_t;

    localparam master_t c_MST_I = 1'b0;
    localparam master_t c_MST_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/atom_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : atom_mem_arbiter_if
// Brief    : Core imem/dmem ports plus the merged downstream memory port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface atom_mem_arbiter_if;

    logic [31:0] imem_addr_i;
    logic        imem_valid_i;
    logic [31:0] imem_data_o;
    logic        imem_ack_o;

    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [3:0]  dmem_sel_i;
    logic        dmem_we_i;
    logic        dmem_valid_i;
    logic [31:0] dmem_data_o;
    logic        dmem_ack_o;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o;
    logic        mem_valid_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    logic        timeout_o;

    // Arbiter side
    modport slave (
        input  imem_addr_i, imem_valid_i,
        output imem_data_o, imem_ack_o,
        input  dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        output dmem_data_o, dmem_ack_o,
        output mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_valid_o,
        input  mem_data_i, mem_ack_i,
        output timeout_o
    );

    // Environment side: core masters and downstream memory
    modport master (
        output imem_addr_i, imem_valid_i,
        input  imem_data_o, imem_ack_o,
        output dmem_addr_i, dmem_data_i, dmem_sel_i, dmem_we_i, dmem_valid_i,
        input  dmem_data_o, dmem_ack_o,
        input  mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_valid_o,
        output mem_data_i, mem_ack_i,
        input  timeout_o
    );

endinterface

`default_nettype wire

// File: rtl/atom_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : atom_mem_arbiter
// Brief    : Merges imem and dmem valid/ack ports onto one registered memory
//            port with fixed or round-robin priority and an ack watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module atom_mem_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 0,
    parameter int TOW         = 8
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    atom_mem_arbiter_if.slave bus
);

    import atom_mem_arbiter_pkg::*;

    state_t         r_state;
    state_t         w_state_nxt;
    master_t        r_last;
    logic [TOW-1:0] r_cnt;
    logic           r_timeout;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_sel;
    logic           r_we;
    logic           r_valid;

    logic w_busy;
    logic w_wd_fire;
    logic w_done;
    logic w_load_i;
    logic w_load_d;

    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    // A real ack always beats the watchdog in the same cycle
    assign w_wd_fire = (TIMEOUT != 0) && w_busy && !bus.mem_ack_i
                       && (r_cnt == TOW'(TIMEOUT));
    assign w_done    = w_busy && (bus.mem_ack_i || w_wd_fire);

    assign bus.imem_ack_o  = (r_state == BUSY_I) && w_done;
    assign bus.dmem_ack_o  = (r_state == BUSY_D) && w_done;
    assign bus.imem_data_o = ((r_state == BUSY_I) && bus.mem_ack_i) ? bus.mem_data_i : '0;
    assign bus.dmem_data_o = ((r_state == BUSY_D) && bus.mem_ack_i) ? bus.mem_data_i : '0;

    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_data_o  = r_wdata;
    assign bus.mem_sel_o   = r_sel;
    assign bus.mem_we_o    = r_we;
    assign bus.mem_valid_o = r_valid;
    assign bus.timeout_o   = r_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // On completion only the other master may be loaded back-to-back; the
    // served master's valid still reflects the request just finished.
    always_comb begin
        w_state_nxt = r_state;
        w_load_i    = 1'b0;
        w_load_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.dmem_valid_i && (!bus.imem_valid_i || (ROUND_ROBIN == 0)
                                         || (r_last == c_MST_I))) begin
                    w_load_d    = 1'b1;
                    w_state_nxt = BUSY_D;
                end else if (bus.imem_valid_i) begin
                    w_load_i    = 1'b1;
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I: begin
                if (w_done) begin
                    if (bus.dmem_valid_i) begin
                        w_load_d    = 1'b1;
                        w_state_nxt = BUSY_D;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            BUSY_D: begin
                if (w_done) begin
                    if (bus.imem_valid_i) begin
                        w_load_i    = 1'b1;
                        w_state_nxt = BUSY_I;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last    <= c_MST_I;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (w_load_i) begin
                r_addr  <= bus.imem_addr_i;
                r_wdata <= '0;
                r_sel   <= 4'hF;
                r_we    <= 1'b0;
                r_valid <= 1'b1;
            end else if (w_load_d) begin
                r_addr  <= bus.dmem_addr_i;
                r_wdata <= bus.dmem_data_i;
                r_sel   <= bus.dmem_sel_i;
                r_we    <= bus.dmem_we_i;
                r_valid <= 1'b1;
            end else if (w_done) begin
                r_valid <= 1'b0;
            end

            if (w_load_i || w_load_d) begin
                r_cnt <= '0;
            end else if (w_busy && !w_done) begin
                r_cnt <= r_cnt + TOW'(1);
            end

            if (w_done) begin
                r_last <= (r_state == BUSY_D) ? c_MST_D : c_MST_I;
            end

            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_atom_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_atom_mem_arbiter
// Brief    : Directed bench: round-robin/watchdog instance and fixed-priority
//            instance driven with hand-computed expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_atom_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    atom_mem_arbiter_if bus_a ();
    atom_mem_arbiter_if bus_b ();

    atom_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4), .TOW(8)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    atom_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0), .TOW(8)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        {bus_a.imem_addr_i, bus_a.imem_valid_i, bus_a.dmem_addr_i, bus_a.dmem_data_i} = '0;
        {bus_a.dmem_sel_i, bus_a.dmem_we_i, bus_a.dmem_valid_i, bus_a.mem_data_i, bus_a.mem_ack_i} = '0;
        {bus_b.imem_addr_i, bus_b.imem_valid_i, bus_b.dmem_addr_i, bus_b.dmem_data_i} = '0;
        {bus_b.dmem_sel_i, bus_b.dmem_we_i, bus_b.dmem_valid_i, bus_b.mem_data_i, bus_b.mem_ack_i} = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_eq("rst_valid",   32'(bus_a.mem_valid_o), 32'd0);
        chk_eq("rst_addr",    bus_a.mem_addr_o,       32'd0);
        chk_eq("rst_sel",     32'(bus_a.mem_sel_o),   32'd0);
        chk_eq("rst_we",      32'(bus_a.mem_we_o),    32'd0);
        chk_eq("rst_timeout", 32'(bus_a.timeout_o),   32'd0);
        chk_eq("rst_b_valid", 32'(bus_b.mem_valid_o), 32'd0);
        rst = 1'b0;

        // Single fetch
        bus_a.imem_addr_i  = 32'h100;
        bus_a.imem_valid_i = 1'b1;
        #1 chk_eq("fetch_pre_valid", 32'(bus_a.mem_valid_o), 32'd0);
        tick();
        chk_eq("fetch_valid", 32'(bus_a.mem_valid_o), 32'd1);
        chk_eq("fetch_addr",  bus_a.mem_addr_o,       32'h100);
        chk_eq("fetch_sel",   32'(bus_a.mem_sel_o),   32'hF);
        chk_eq("fetch_we",    32'(bus_a.mem_we_o),    32'd0);
        chk_eq("fetch_wdata", bus_a.mem_data_o,       32'd0);
        chk_eq("fetch_noack", 32'(bus_a.imem_ack_o),  32'd0);
        tick();
        bus_a.mem_data_i = 32'h13;
        bus_a.mem_ack_i  = 1'b1;
        #1;
        chk_eq("fetch_ack",   32'(bus_a.imem_ack_o),  32'd1);
        chk_eq("fetch_data",  bus_a.imem_data_o,      32'h13);
        chk_eq("fetch_dack",  32'(bus_a.dmem_ack_o),  32'd0);
        chk_eq("fetch_ddata", bus_a.dmem_data_o,      32'd0);
        tick();
        bus_a.imem_valid_i = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1;
        chk_eq("fetch_idle_valid", 32'(bus_a.mem_valid_o), 32'd0);
        chk_eq("fetch_ack_pulse",  32'(bus_a.imem_ack_o),  32'd0);

        // Store
        bus_a.dmem_addr_i  = 32'h2000;
        bus_a.dmem_data_i  = 32'hA5A5A5A5;
        bus_a.dmem_sel_i   = 4'h3;
        bus_a.dmem_we_i    = 1'b1;
        bus_a.dmem_valid_i = 1'b1;
        tick();
        chk_eq("store_addr",  bus_a.mem_addr_o,       32'h2000);
        chk_eq("store_wdata", bus_a.mem_data_o,       32'hA5A5A5A5);
        chk_eq("store_sel",   32'(bus_a.mem_sel_o),   32'h3);
        chk_eq("store_we",    32'(bus_a.mem_we_o),    32'd1);
        chk_eq("store_valid", 32'(bus_a.mem_valid_o), 32'd1);
        chk_eq("store_noack", 32'(bus_a.dmem_ack_o),  32'd0);
        bus_a.mem_data_i = 32'h0BADF00D;
        bus_a.mem_ack_i  = 1'b1;
        #1;
        chk_eq("store_ack",  32'(bus_a.dmem_ack_o), 32'd1);
        chk_eq("store_iack", 32'(bus_a.imem_ack_o), 32'd0);
        tick();
        bus_a.dmem_valid_i = 1'b0;
        bus_a.dmem_we_i    = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1 chk_eq("store_idle_valid", 32'(bus_a.mem_valid_o), 32'd0);

        // Tie right after dmem was served: round-robin hands it to imem
        bus_a.imem_addr_i  = 32'h300;
        bus_a.imem_valid_i = 1'b1;
        bus_a.dmem_addr_i  = 32'h400;
        bus_a.dmem_sel_i   = 4'hF;
        bus_a.dmem_valid_i = 1'b1;
        tick();
        chk_eq("rr_tie_after_d", bus_a.mem_addr_o, 32'h300);
        bus_a.mem_ack_i = 1'b1;
        #1;
        chk_eq("rr_tie_iack", 32'(bus_a.imem_ack_o), 32'd1);
        chk_eq("rr_tie_dack", 32'(bus_a.dmem_ack_o), 32'd0);
        tick();
        chk_eq("rr_b2b_valid", 32'(bus_a.mem_valid_o), 32'd1);
        chk_eq("rr_b2b_addr",  bus_a.mem_addr_o,       32'h400);
        chk_eq("rr_b2b_dack",  32'(bus_a.dmem_ack_o),  32'd1);
        bus_a.imem_valid_i = 1'b0;
        tick();
        bus_a.dmem_valid_i = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1 chk_eq("rr_b2b_idle", 32'(bus_a.mem_valid_o), 32'd0);

        // Tie from reset with both held valid: D, I, D, I with no bubbles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.mem_data_i   = 32'h55;
        bus_a.mem_ack_i    = 1'b1;
        bus_a.imem_valid_i = 1'b1;
        bus_a.dmem_valid_i = 1'b1;
        #1;
        chk_eq("idle_spurious_iack", 32'(bus_a.imem_ack_o), 32'd0);
        chk_eq("idle_spurious_dack", 32'(bus_a.dmem_ack_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            tick();
            chk_eq($sformatf("alt%0d_valid", k), 32'(bus_a.mem_valid_o), 32'd1);
            chk_eq($sformatf("alt%0d_addr", k),  bus_a.mem_addr_o, exp_d ? 32'h400 : 32'h300);
            chk_eq($sformatf("alt%0d_dack", k),  32'(bus_a.dmem_ack_o), 32'(exp_d));
            chk_eq($sformatf("alt%0d_iack", k),  32'(bus_a.imem_ack_o), 32'(!exp_d));
        end
        bus_a.dmem_valid_i = 1'b0;
        tick();
        bus_a.imem_valid_i = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1 chk_eq("alt_idle", 32'(bus_a.mem_valid_o), 32'd0);

        // Fixed priority: dmem wins the tie even right after it was served
        bus_b.dmem_addr_i  = 32'h600;
        bus_b.dmem_sel_i   = 4'hF;
        bus_b.dmem_valid_i = 1'b1;
        tick();
        bus_b.mem_ack_i = 1'b1;
        #1 chk_eq("fix_first_dack", 32'(bus_b.dmem_ack_o), 32'd1);
        tick();
        bus_b.imem_addr_i  = 32'h700;
        bus_b.imem_valid_i = 1'b1;
        tick();
        chk_eq("fix_tie_d",    bus_b.mem_addr_o,      32'h600);
        chk_eq("fix_tie_dack", 32'(bus_b.dmem_ack_o), 32'd1);
        tick();
        chk_eq("fix_b2b_i",    bus_b.mem_addr_o,      32'h700);
        chk_eq("fix_b2b_iack", 32'(bus_b.imem_ack_o), 32'd1);
        bus_b.dmem_valid_i = 1'b0;
        tick();
        bus_b.imem_valid_i = 1'b0;
        bus_b.mem_ack_i    = 1'b0;
        #1 chk_eq("fix_idle", 32'(bus_b.mem_valid_o), 32'd0);

        // Real ack on the exact watchdog cycle wins
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_a.dmem_addr_i  = 32'h500;
        bus_a.dmem_valid_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("coin_wait%0d", k), 32'(bus_a.dmem_ack_o), 32'd0);
            tick();
        end
        bus_a.mem_data_i = 32'h77;
        bus_a.mem_ack_i  = 1'b1;
        #1;
        chk_eq("coin_ack",  32'(bus_a.dmem_ack_o), 32'd1);
        chk_eq("coin_data", bus_a.dmem_data_o,     32'h77);
        tick();
        bus_a.dmem_valid_i = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1;
        chk_eq("coin_no_timeout", 32'(bus_a.timeout_o),   32'd0);
        chk_eq("coin_idle",       32'(bus_a.mem_valid_o), 32'd0);

        // Watchdog fires 4 cycles after the grant
        bus_a.dmem_addr_i  = 32'h800;
        bus_a.dmem_valid_i = 1'b1;
        bus_a.mem_data_i   = 32'hFFFFFFFF;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_eq($sformatf("wd_wait%0d", k), 32'(bus_a.dmem_ack_o), 32'd0);
            tick();
        end
        chk_eq("wd_ack",        32'(bus_a.dmem_ack_o), 32'd1);
        chk_eq("wd_data",       bus_a.dmem_data_o,     32'd0);
        chk_eq("wd_flag_early", 32'(bus_a.timeout_o),  32'd0);
        tick();
        bus_a.dmem_valid_i = 1'b0;
        #1;
        chk_eq("wd_flag", 32'(bus_a.timeout_o),   32'd1);
        chk_eq("wd_idle", 32'(bus_a.mem_valid_o), 32'd0);
        bus_a.mem_ack_i = 1'b1;
        #1;
        chk_eq("late_dack", 32'(bus_a.dmem_ack_o), 32'd0);
        chk_eq("late_iack", 32'(bus_a.imem_ack_o), 32'd0);
        tick();
        chk_eq("wd_sticky",     32'(bus_a.timeout_o),   32'd1);
        chk_eq("late_no_grant", 32'(bus_a.mem_valid_o), 32'd0);
        bus_a.mem_ack_i = 1'b0;

        // Reset in the middle of a fetch
        bus_a.imem_addr_i  = 32'h900;
        bus_a.imem_valid_i = 1'b1;
        tick();
        chk_eq("mid_busy", 32'(bus_a.mem_valid_o), 32'd1);
        bus_a.mem_ack_i = 1'b1;
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_valid", 32'(bus_a.mem_valid_o), 32'd0);
        chk_eq("mid_rst_iack",  32'(bus_a.imem_ack_o),  32'd0);
        chk_eq("mid_rst_flag",  32'(bus_a.timeout_o),   32'd0);
        tick();
        rst = 1'b0;
        bus_a.mem_ack_i   = 1'b0;
        bus_a.imem_addr_i = 32'hA00;
        tick();
        chk_eq("post_rst_valid", 32'(bus_a.mem_valid_o), 32'd1);
        chk_eq("post_rst_addr",  bus_a.mem_addr_o,       32'hA00);
        bus_a.mem_data_i = 32'h1234;
        bus_a.mem_ack_i  = 1'b1;
        #1;
        chk_eq("post_rst_iack", 32'(bus_a.imem_ack_o), 32'd1);
        chk_eq("post_rst_data", bus_a.imem_data_o,     32'h1234);
        tick();
        bus_a.imem_valid_i = 1'b0;
        bus_a.mem_ack_i    = 1'b0;
        #1 chk_eq("post_rst_idle", 32'(bus_a.mem_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
